// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch prefetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with synchronous flush; used for the instruction queue
// and for the PCs of outstanding memory requests.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            push,
  input  logic                            pop,
  input  logic [WIDTH-1:0]                wdata,
  output logic [WIDTH-1:0]                rdata,
  output logic                            full,
  output logic                            empty,
  output logic [count_width(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: issues word-addressed requests, tracks in-flight and stale
// responses across redirects, and buffers instructions for decode.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter logic [XLEN-1:0]   PC_STEP  = XLEN'(1),
  parameter logic [XLEN-1:0]   NOP      = XLEN'(NOP_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_rsp_valid,
  input  logic [XLEN-1:0]               imem_rsp_data,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [XLEN-1:0]               dec_instr,
  output logic [XLEN-1:0]               dec_pc,
  output logic [XLEN-1:0]               dec_npc,
  output logic [count_width(DEPTH)-1:0] occupancy
);

  localparam int CW = count_width(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [CW:0]     credit_used;
  logic            fire;
  logic            rsp_ok;
  logic            enq;
  logic            deq;
  entry_t          q_wdata;
  entry_t          q_rdata;
  logic            q_full;
  logic            q_empty;
  logic [XLEN-1:0] a_rdata;
  logic            a_full;
  logic            a_empty;
  logic [CW-1:0]   a_count;
  logic            unused_status;

  // Credits count registered state only, so a dequeue this cycle frees nothing yet.
  assign credit_used    = {1'b0, occupancy} + {1'b0, inflight};
  assign imem_req_valid = !reset && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign fire           = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok = imem_rsp_valid && (inflight != '0);
  assign enq    = rsp_ok && (discard == '0) && !redirect && !a_empty;
  assign deq    = !q_empty && dec_ready && !redirect;

  assign q_wdata.instr = imem_rsp_data;
  assign q_wdata.pc    = a_rdata;

  assign unused_status = ^{q_full, a_full, a_count};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect) begin
      // Everything still outstanding after this edge belongs to the old stream.
      pc_q     <= redirect_pc;
      inflight <= inflight - CW'(rsp_ok);
      discard  <= inflight - CW'(rsp_ok);
    end else begin
      if (fire) pc_q <= pc_q + PC_STEP;
      inflight <= inflight + CW'(fire) - CW'(rsp_ok);
      if (rsp_ok && discard != '0) discard <= discard - 1'b1;
    end
  end

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_q (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (enq),
    .pop   (deq),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (occupancy)
  );

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (fire),
    .pop   (enq),
    .wdata (pc_q),
    .rdata (a_rdata),
    .full  (a_full),
    .empty (a_empty),
    .count (a_count)
  );

  assign dec_valid = !q_empty;
  assign dec_instr = dec_valid ? q_rdata.instr : NOP;
  assign dec_pc    = dec_valid ? q_rdata.pc : '0;
  assign dec_npc   = dec_pc + PC_STEP;

  property p_no_orphan_rsp;
    @(posedge clk) disable iff (reset) imem_rsp_valid |-> (inflight != '0);
  endproperty
  a_no_orphan_rsp: assert property (p_no_orphan_rsp);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit against a queue-based reference of
// the fetch stream and an in-order variable-latency memory.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_npc;
  logic [2:0]  occupancy;

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_npc        (dec_npc),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t         mem_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  model_pc;
  logic [31:0]  last_pc;
  bit           have_last;
  int           epoch;
  int           cyc;
  int           total;
  int           bad;
  int           rdy_pct, dec_pct, lat_lo, lat_hi;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic knobs(input int r, input int lo, input int hi, input int d);
    rdy_pct = r; lat_lo = lo; lat_hi = hi; dec_pct = d;
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic cycle(input logic redir, input logic [31:0] rpc);
    logic  rsp, exp_rv, fire, deq;
    req_t  h;
    fetch_entry_t e;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    dec_ready      = ($urandom_range(99) < dec_pct);
    redirect       = redir;
    redirect_pc    = rpc;
    rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
    @(negedge clk);
    exp_rv = !redir && (exp_q.size() + mem_q.size() < DEPTH);
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr, model_pc);
    check("occupancy", occupancy, exp_q.size());
    check("dec_valid", dec_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("dec_pc", dec_pc, exp_q[0].pc);
      check("dec_instr", dec_instr, exp_q[0].instr);
      check("dec_npc", dec_npc, exp_q[0].pc + 32'd1);
    end else begin
      check("dec_instr_nop", dec_instr, NOP_DEFAULT);
    end
    fire = imem_req_valid && imem_req_ready;
    deq  = (exp_q.size() > 0) && dec_ready && !redir;
    if (deq) begin
      if (have_last) check("contiguous", dec_pc, last_pc + 32'd1);
      last_pc   = dec_pc;
      have_last = 1'b1;
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
      model_pc  = rpc;
      have_last = 1'b0;
      if (rsp) void'(mem_q.pop_front());
    end else begin
      if (deq) void'(exp_q.pop_front());
      if (rsp) begin
        h = mem_q.pop_front();
        if (h.epoch == epoch) begin
          check("no_overflow", exp_q.size() < DEPTH, 1'b1);
          e.instr = mem_word(h.addr);
          e.pc    = h.addr;
          exp_q.push_back(e);
        end
      end
    end
    if (fire) begin
      mem_q.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_hi, lat_lo), epoch: epoch});
      model_pc = model_pc + 32'd1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    dec_ready      = 1'b0;
    #1;
    check("rst_dec_valid", dec_valid, 1'b0);
    check("rst_occupancy", occupancy, 3'd0);
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_dec_instr", dec_instr, NOP_DEFAULT);
    check("rst_dec_pc", dec_pc, 32'd0);
    check("rst_dec_npc", dec_npc, 32'd1);
    mem_q.delete();
    exp_q.delete();
    model_pc  = 32'd0;
    have_last = 1'b0;
    epoch++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    int n = 0;
    while (!dec_valid && n < 30) begin
      cycle(1'b0, 32'd0);
      n++;
    end
    check({tag, "_valid"}, dec_valid, 1'b1);
    check(tag, dec_pc, exp_pc);
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b0;
    total = 0; bad = 0; cyc = 0; epoch = 0; model_pc = '0; last_pc = '0; have_last = 1'b0;
    knobs(100, 1, 1, 100);
    #2;
    do_reset();

    // Back-to-back fetch with single-cycle memory.
    knobs(100, 1, 1, 100);
    repeat (12) cycle(1'b0, 32'd0);

    // Decode stalled: queue fills to DEPTH and requests stop.
    knobs(100, 2, 2, 0);
    repeat (10) cycle(1'b0, 32'd0);
    check("sat_occupancy", occupancy, 3'd4);
    check("sat_req_valid", imem_req_valid, 1'b0);
    knobs(100, 2, 2, 100);
    repeat (10) cycle(1'b0, 32'd0);

    // Redirect with requests in flight at latency 3.
    knobs(100, 3, 3, 100);
    repeat (10) cycle(1'b0, 32'd0);
    cycle(1'b1, 32'h40);
    check("flush_occupancy", occupancy, 3'd0);
    check("flush_dec_valid", dec_valid, 1'b0);
    wait_valid("redir40_pc", 32'h40);
    repeat (6) cycle(1'b0, 32'd0);

    // Redirect coincident with a response, then a second one while stale data is pending.
    for (int n = 0; n < 10 && !(mem_q.size() > 0 && mem_q[0].due <= cyc); n++) cycle(1'b0, 32'd0);
    cycle(1'b1, 32'h200);
    cycle(1'b1, 32'h80);
    wait_valid("redir80_pc", 32'h80);
    repeat (6) cycle(1'b0, 32'd0);

    // Random ready, latency, back-pressure and redirects (one across the PC wrap).
    knobs(60, 1, 5, 70);
    for (int i = 0; i < 500; i++) begin
      if (i == 250)                   cycle(1'b1, 32'hFFFF_FFFE);
      else if ($urandom_range(99) < 3) cycle(1'b1, $urandom);
      else                            cycle(1'b0, 32'd0);
    end

    // Reset in the middle of a stream with a full queue.
    knobs(100, 2, 2, 0);
    repeat (12) cycle(1'b0, 32'd0);
    check("pre_reset_occupancy", occupancy, 3'd4);
    do_reset();
    knobs(100, 1, 1, 100);
    repeat (10) cycle(1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised instruction-fetch front end with an in-order prefetch queue. It decouples PC generation from decode. It issues word-addressed requests to a variable-latency instruction memory, buffers up to DEPTH returned instructions with their PC, and presents them to decode over a valid/ready handshake. It sits between the PC-control/hazard logic, which supplies redirects and decode back-pressure, and the ID stage.

## Interface
- XLEN, 32: instruction and address width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: fetch PC after reset.
- PC_STEP, 1: PC increment per instruction (word addressing).
- NOP, 32'h0000_0000: value driven on dec_instr when dec_valid is low.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- redirect  in  1  flush and restart fetch at redirect_pc (branch, jump, JR target resolved upstream).
- redirect_pc  in  XLEN  new fetch address.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address, equal to fetch PC.
- imem_rsp_valid  in  1  response valid, one per accepted request, strictly in order.
- imem_rsp_data  in  XLEN  instruction word.
- dec_valid  out  1  head entry valid.
- dec_ready  in  1  decode accepts head.
- dec_instr  out  XLEN  head instruction, or NOP when dec_valid is 0.
- dec_pc  out  XLEN  PC of head instruction.
- dec_npc  out  XLEN  dec_pc + PC_STEP.
- occupancy  out  $clog2(DEPTH+1)  valid queue entries.

## Operation
- State:
  - fetch PC register pc_q.
  - queue of {instr, pc} entries.
  - inflight counter: requests accepted, response not yet seen.
  - discard counter: stale responses still to drop.
- Request issue:
  - imem_req_valid = !reset && !redirect && (occupancy + inflight < DEPTH).
  - The credit check uses registered values only; a same-cycle dequeue does not free a credit.
- Request fire (valid && ready): pc_q += PC_STEP, modulo 2^XLEN; inflight += 1.
- Response (imem_rsp_valid): inflight −= 1.
  - If discard > 0 or redirect is high: the response is dropped. If discard > 0, discard −= 1.
  - Otherwise: enqueue {imem_rsp_data, pc of the oldest outstanding request}. The pc of each accepted request is tracked in a DEPTH-entry address FIFO.
- Dequeue on dec_valid && dec_ready. Enqueue and dequeue may occur in the same cycle, including when the queue is full or empty.
- Redirect, single-cycle, highest priority:
  - pc_q <= redirect_pc.
  - Queue and address FIFO cleared.
  - discard <= inflight − (imem_rsp_valid ? 1 : 0), with inflight updated to the same value.
  - No request is issued and no dequeue occurs that cycle; dec_valid is still driven from the pre-flush queue but dec_ready is ignored.
- Redirect while discard > 0: the new discard value is the total remaining inflight, so older stale responses are covered.
- Overflow is impossible by construction. The bench asserts the queue never receives an enqueue while full with no dequeue.
- A response with inflight = 0 is a protocol error. Flag it via an assertion; the unit ignores the response.

## Timing
- Reset values:
  - pc_q = RESET_PC; inflight = 0; discard = 0; occupancy = 0.
  - dec_valid = 0; dec_instr = NOP; dec_pc = 0; dec_npc = PC_STEP.
  - imem_req_valid = 0 while reset is high.
- A reset asserted mid-operation abandons all in-flight state immediately. Memory must also be reset so that no post-reset responses arrive for pre-reset requests.
- First request: the first clk edge after reset deasserts can fire at address RESET_PC.
- Latency: a response at edge t is visible on dec_valid/dec_instr after edge t (registered queue, no bypass). The best-case request-to-decode time is memory latency + 1.
- Redirect at edge t: the first request to redirect_pc can fire at edge t+1. dec_valid is 0 after edge t until new responses return.
- Throughput: one instruction per cycle sustained when memory latency < DEPTH.

## Structure
- Package fetch_pkg:
  - NOP default.
  - fetch_entry_t struct {instr, pc}.
  - Helper function for counter width, $clog2(DEPTH+1).
- Sub-module fetch_fifo:
  - Parametrised synchronous FIFO (WIDTH, DEPTH) with synchronous flush, full/empty, and count.
  - Instantiated twice: instruction queue and outstanding-address FIFO.
- Top level holds pc_q, the inflight/discard counters, and the request/redirect control.

## Test plan
- Reset release, zero-latency memory, dec_ready = 1 → requests to 0,1,2,3…; dec_pc is 0,1,2… one per cycle, with dec_npc = dec_pc + 1.
- dec_ready = 0 held, memory latency 2 → exactly DEPTH = 4 requests accepted; occupancy saturates at 4; imem_req_valid drops; no data loss after release.
- Redirect to 0x40 with 3 requests in flight (latency 3) → 3 responses dropped; next dec_pc = 0x40; queue is empty in the cycle after the redirect.
- Redirect coincident with imem_rsp_valid, then a second redirect to 0x80 while discard = 2 → all stale responses dropped; first delivered dec_pc = 0x80.
- imem_req_ready toggled randomly, random latency 1–5 → delivered PC sequence is contiguous with no duplicates or gaps.
- Reset asserted mid-stream with a full queue → all outputs return to reset values in the same cycle; fetch restarts at RESET_PC.
